// File: rtl/pio_counter_ctrl.sv
// PIO-controlled 64-bit up-counter with a target compare and an IDLE/RUN/DONE sequencer.
// Registers sit on a small word-addressed PIO bus; reads have a one-cycle latency.
module pio_counter_ctrl #(
   parameter logic [31:0] SERIAL  = 32'h0022_1102,
   parameter int unsigned LED_BIT = 26
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pio_hwen,
   input  logic [31:0] pio_addr,
   input  logic [31:0] pio_wdata,
   output logic [31:0] pio_rdata,
   output logic [63:0] count,
   output logic        finished,
   output logic        busy,
   output logic        led
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [2:0] AddrCtrl     = 3'd0;
   localparam logic [2:0] AddrTargetLo = 3'd1;
   localparam logic [2:0] AddrTargetHi = 3'd2;
   localparam logic [2:0] AddrCountLo  = 3'd3;
   localparam logic [2:0] AddrCountHi  = 3'd4;
   localparam logic [2:0] AddrSerial   = 3'd5;

   state_e      state_q, state_d;
   logic [63:0] count_q, count_d;
   logic [31:0] target_lo_q, target_lo_d;
   logic [31:0] target_hi_q, target_hi_d;
   logic [31:0] snap_q, snap_d;
   logic [31:0] rdata_q, rdata_d;

   logic        addr_hit;
   logic [2:0]  addr_lo;
   logic        ctrl_wr;
   logic        cmd_start, cmd_stop, cmd_clear;
   logic [63:0] target;
   logic [63:0] count_inc;

   // Any nonzero upper address bit is a miss, so aliases of the map never decode.
   assign addr_hit  = (pio_addr[31:3] == 29'd0);
   assign addr_lo   = pio_addr[2:0];
   assign ctrl_wr   = pio_hwen && addr_hit && (addr_lo == AddrCtrl);
   assign cmd_clear = ctrl_wr && pio_wdata[2];
   assign cmd_stop  = ctrl_wr && pio_wdata[1];
   assign cmd_start = ctrl_wr && pio_wdata[0];

   assign target    = {target_hi_q, target_lo_q};
   assign count_inc = count_q + 64'd1;

   // Sequencer and counter next state; clear outranks stop, stop outranks start.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (cmd_clear) begin
         state_d = StIdle;
         count_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (!cmd_stop && cmd_start) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               if (cmd_stop) begin
                  state_d = StIdle;
               end else if (count_q >= target) begin
                  state_d = StDone;
               end else begin
                  count_d = count_inc;
                  if (count_inc == target) begin
                     state_d = StDone;
                  end
               end
            end
            StDone: begin
               state_d = StDone;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_comb begin
      target_lo_d = target_lo_q;
      target_hi_d = target_hi_q;
      if (pio_hwen && addr_hit) begin
         if (addr_lo == AddrTargetLo) begin
            target_lo_d = pio_wdata;
         end
         if (addr_lo == AddrTargetHi) begin
            target_hi_d = pio_wdata;
         end
      end
   end

   // Reading COUNT_LO latches the upper half so a following COUNT_HI read is coherent.
   always_comb begin
      rdata_d = 32'd0;
      snap_d  = snap_q;
      if (addr_hit) begin
         case (addr_lo)
            AddrCtrl:     rdata_d = {30'd0, (state_q == StDone), (state_q == StRun)};
            AddrTargetLo: rdata_d = target_lo_q;
            AddrTargetHi: rdata_d = target_hi_q;
            AddrCountLo: begin
               rdata_d = count_q[31:0];
               snap_d  = count_q[63:32];
            end
            AddrCountHi:  rdata_d = snap_q;
            AddrSerial:   rdata_d = SERIAL;
            default:      rdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         count_q     <= '0;
         target_lo_q <= '0;
         target_hi_q <= '0;
         snap_q      <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         target_lo_q <= target_lo_d;
         target_hi_q <= target_hi_d;
         snap_q      <= snap_d;
         rdata_q     <= rdata_d;
      end
   end

   // Status outputs come only from registered state, never from the bus inputs.
   always_comb begin
      led = 1'b0;
      case (state_q)
         StRun:   led = count_q[LED_BIT];
         StDone:  led = 1'b1;
         default: led = 1'b0;
      endcase
   end

   assign busy      = (state_q == StRun);
   assign finished  = (state_q == StDone);
   assign count     = count_q;
   assign pio_rdata = rdata_q;

endmodule

// File: tb/tb_pio_counter_ctrl.sv
// Directed bench for pio_counter_ctrl: a register-map vector table plus hand-written
// sequences for run/stop/clear, target edge cases, snapshot reads and async reset.
module tb_pio_counter_ctrl;

   logic        clk;
   logic        reset;
   logic        pio_hwen;
   logic [31:0] pio_addr;
   logic [31:0] pio_wdata;
   logic [31:0] pio_rdata;
   logic [63:0] count;
   logic        finished;
   logic        busy;
   logic        led;

   int total = 0;
   int bad   = 0;

   pio_counter_ctrl #(
      .SERIAL (32'h0022_1102),
      .LED_BIT(2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .pio_hwen (pio_hwen),
      .pio_addr (pio_addr),
      .pio_wdata(pio_wdata),
      .pio_rdata(pio_rdata),
      .count    (count),
      .finished (finished),
      .busy     (busy),
      .led      (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance past one rising edge; outputs are sampled 1 ns later.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      pio_hwen  = 1'b1;
      pio_addr  = a;
      pio_wdata = d;
      step(1);
      pio_hwen  = 1'b0;
      pio_addr  = 32'd0;
      pio_wdata = 32'd0;
   endtask

   task automatic set_target(input logic [63:0] t);
      wr(32'd1, t[31:0]);
      wr(32'd2, t[63:32]);
   endtask

   task automatic wait_finished(input string name, input int limit);
      int n;
      n = 0;
      while (!finished && n < limit) begin
         step(1);
         n++;
      end
      check(name, {63'd0, finished}, 64'd1);
   endtask

   initial begin
      int n;
      logic [31:0] lo_rd;
      logic [31:0] hi_rd;

      reset     = 1'b0;
      pio_hwen  = 1'b0;
      pio_addr  = 32'd0;
      pio_wdata = 32'd0;

      vecs[0]  = '{1'b1, 32'h1, 32'hdead_beef, 32'h0};
      vecs[1]  = '{1'b0, 32'h1, 32'h0,         32'hdead_beef};
      vecs[2]  = '{1'b1, 32'h2, 32'h1234_5678, 32'h0};
      vecs[3]  = '{1'b0, 32'h2, 32'h0,         32'h1234_5678};
      vecs[4]  = '{1'b1, 32'h3, 32'h55,        32'h0};
      vecs[5]  = '{1'b0, 32'h3, 32'h0,         32'h0};
      vecs[6]  = '{1'b1, 32'h5, 32'h1,         32'h0022_1102};
      vecs[7]  = '{1'b0, 32'h5, 32'h0,         32'h0022_1102};
      vecs[8]  = '{1'b0, 32'h7, 32'h0,         32'h0};
      vecs[9]  = '{1'b0, 32'h9, 32'h0,         32'h0};
      vecs[10] = '{1'b1, 32'h9, 32'h11,        32'h0};
      vecs[11] = '{1'b0, 32'h1, 32'h0,         32'hdead_beef};
      vecs[12] = '{1'b1, 32'h8, 32'h1,         32'h0};
      vecs[13] = '{1'b0, 32'h0, 32'h0,         32'h0};
      vecs[14] = '{1'b0, 32'h6, 32'h0,         32'h0};

      #12;
      check("reset_count", count, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_finished", {63'd0, finished}, 64'd0);
      check("reset_led", {63'd0, led}, 64'd0);
      check("reset_rdata", {32'd0, pio_rdata}, 64'd0);
      #10 reset = 1'b1;
      step(1);
      check("post_reset_idle", {62'd0, finished, busy}, 64'd0);

      // Register map table, applied in IDLE with count at zero.
      foreach (vecs[i]) begin
         pio_hwen  = vecs[i].we;
         pio_addr  = vecs[i].addr;
         pio_wdata = vecs[i].wdata;
         step(1);
         check($sformatf("vec%0d", i), {32'd0, pio_rdata}, {32'd0, vecs[i].exp});
      end
      pio_hwen = 1'b0;
      pio_addr = 32'd0;
      check("alias_ctrl_no_start", {63'd0, busy}, 64'd0);

      // Basic run to target 10.
      set_target(64'd10);
      wr(32'd0, 32'h1);
      n = 0;
      while (busy && n < 100) begin
         n++;
         step(1);
      end
      check("run10_busy_cycles", n, 64'd10);
      check("run10_count", count, 64'd10);
      check("run10_finished", {62'd0, finished, busy}, 64'd2);
      check("run10_led_done", {63'd0, led}, 64'd1);
      step(5);
      check("run10_stable", count, 64'd10);
      step(1);
      check("ctrl_read_done", {32'd0, pio_rdata}, 64'd2);
      wr(32'd0, 32'h3);
      check("done_ignores_start_stop", {62'd0, finished, busy}, 64'd2);
      check("done_count_held", count, 64'd10);

      // Pause at 40 and resume to 100.
      wr(32'd0, 32'h4);
      check("clear_count", count, 64'd0);
      wr(32'd0, 32'h3);
      check("idle_stop_beats_start", {63'd0, busy}, 64'd0);
      set_target(64'd100);
      wr(32'd0, 32'h1);
      step(40);
      check("pause_at40", count, 64'd40);
      wr(32'd0, 32'h2);
      check("pause_idle", {62'd0, finished, busy}, 64'd0);
      step(20);
      check("pause_held", count, 64'd40);
      check("pause_led", {63'd0, led}, 64'd0);
      wr(32'd0, 32'h1);
      check("resume_count", count, 64'd40);
      check("resume_led_lo", {63'd0, led}, 64'd0);
      step(4);
      check("resume_led_hi", {63'd0, led}, 64'd1);
      wait_finished("pause_done", 200);
      check("pause_final", count, 64'd100);

      // Clear+stop+start during RUN.
      wr(32'd0, 32'h4);
      wr(32'd0, 32'h1);
      step(5);
      check("pre_clear_count", count, 64'd5);
      wr(32'd0, 32'h7);
      check("cmd7_count", count, 64'd0);
      check("cmd7_state", {62'd0, finished, busy}, 64'd0);

      // Target zero.
      set_target(64'd0);
      wr(32'd0, 32'h1);
      check("t0_run", {62'd0, finished, busy}, 64'd1);
      step(1);
      check("t0_done", {62'd0, finished, busy}, 64'd2);
      check("t0_count", count, 64'd0);

      // Lower target below count mid-run.
      wr(32'd0, 32'h4);
      set_target(64'd100);
      wr(32'd0, 32'h1);
      step(20);
      check("lower_pre", count, 64'd20);
      wr(32'd1, 32'd5);
      check("lower_edge_count", count, 64'd21);
      step(1);
      check("lower_done", {62'd0, finished, busy}, 64'd2);
      step(3);
      check("lower_held", count, 64'd21);

      // Snapshot reads against a 33-bit target.
      wr(32'd0, 32'h4);
      set_target(64'h1_0000_0005);
      wr(32'd0, 32'h1);
      step(9);
      pio_addr = 32'd3;
      step(1);
      lo_rd = pio_rdata;
      pio_addr = 32'd4;
      step(1);
      hi_rd = pio_rdata;
      check("snap_pair", {hi_rd, lo_rd}, 64'd9);
      check("snap_running", count, 64'd11);
      pio_addr = 32'd2;
      step(1);
      check("target_hi_rd", {32'd0, pio_rdata}, 64'd1);
      pio_addr = 32'd5;
      step(1);
      check("serial_rd", {32'd0, pio_rdata}, 64'h0022_1102);
      pio_addr = 32'd7;
      step(1);
      check("addr7_rd", {32'd0, pio_rdata}, 64'd0);
      pio_addr = 32'd0;

      // Maximum target keeps counting.
      wr(32'd0, 32'h4);
      set_target(64'hFFFF_FFFF_FFFF_FFFF);
      wr(32'd0, 32'h1);
      step(3);
      check("max_target_run", {count[62:0], busy}, {63'd3, 1'b1});

      // Async reset mid-run at 57.
      wr(32'd0, 32'h4);
      set_target(64'd100);
      pio_addr = 32'd5;
      wr(32'd0, 32'h1);
      pio_addr = 32'd5;
      step(57);
      check("rst_pre_count", count, 64'd57);
      check("rst_pre_rdata", {32'd0, pio_rdata}, 64'h0022_1102);
      #3 reset = 1'b0;
      #1;
      check("rst_async_count", count, 64'd0);
      check("rst_async_flags", {61'd0, led, finished, busy}, 64'd0);
      check("rst_async_rdata", {32'd0, pio_rdata}, 64'd0);
      #3 reset = 1'b1;
      pio_addr = 32'd0;
      step(3);
      check("rst_stays_idle", {count[61:0], finished, busy}, 64'd0);
      pio_addr = 32'd1;
      step(1);
      check("rst_target_cleared", {32'd0, pio_rdata}, 64'd0);
      pio_addr = 32'd0;
      set_target(64'd100);
      wr(32'd0, 32'h1);
      step(3);
      check("rst_restart", count, 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
